// File: rtl/nn_train_sequencer.sv
// Iteration scheduler for the NN_CORE 2-3-2 backprop datapath.
// Drives one-hot phase enables, sample index and run status.
module nn_train_sequencer #(
  parameter int N_ITER    = 10000,
  parameter int N_SAMPLES = 4,
  parameter int ITER_W    = 16,
  parameter int SMP_W     = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              stop,
  output logic              select_initial,
  output logic              en_fwd2,
  output logic              en_fwd3,
  output logic              en_err,
  output logic              en_dlt3,
  output logic              en_dlt2,
  output logic              en_upd,
  output logic [SMP_W-1:0]  sample_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, INIT, FWD2, FWD3, ERR,
    DLT3, DLT2, UPD, NEXT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        ph, ph_nxt, ph_last;
  logic              stop_pend, stop_pend_nxt;
  logic [ITER_W-1:0] iter_nxt, iter_inc;
  logic [SMP_W-1:0]  smp_nxt;
  logic              last_iter, done_nxt;
  logic [6:0]        en_q, en_nxt;

  assign iter_inc  = iter_cnt + 1'b1;
  assign last_iter = (iter_inc == ITER_W'(N_ITER));

  always_comb begin
    ph_last = 2'd0;
    unique case (state)
      FWD2, FWD3, DLT3, DLT2: ph_last = 2'd1;
      UPD:                    ph_last = 2'd2;
      default:                ph_last = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    ph_nxt        = ph;
    stop_pend_nxt = stop_pend;
    iter_nxt      = iter_cnt;
    smp_nxt       = sample_idx;
    done_nxt      = 1'b0;
    if (state != IDLE && stop)
      stop_pend_nxt = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = INIT;
          ph_nxt        = 2'd0;
          iter_nxt      = '0;
          smp_nxt       = '0;
          stop_pend_nxt = 1'b0;
        end
      end
      NEXT: begin
        iter_nxt = iter_inc;
        smp_nxt  = (sample_idx == SMP_W'(N_SAMPLES - 1))
                   ? '0 : sample_idx + 1'b1;
        ph_nxt   = 2'd0;
        if (last_iter || stop_pend || stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = FWD2;
        end
      end
      default: begin
        // phase states are declared in execution order
        if (ph == ph_last) begin
          ph_nxt    = 2'd0;
          state_nxt = state_t'(state + 4'd1);
        end else begin
          ph_nxt = ph + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    en_nxt = 7'b0;
    unique case (state_nxt)
      INIT:    en_nxt = 7'b1000000;
      FWD2:    en_nxt = 7'b0100000;
      FWD3:    en_nxt = 7'b0010000;
      ERR:     en_nxt = 7'b0001000;
      DLT3:    en_nxt = 7'b0000100;
      DLT2:    en_nxt = 7'b0000010;
      UPD:     en_nxt = 7'b0000001;
      default: en_nxt = 7'b0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      ph         <= 2'd0;
      stop_pend  <= 1'b0;
      iter_cnt   <= '0;
      sample_idx <= '0;
      en_q       <= 7'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ph         <= ph_nxt;
      stop_pend  <= stop_pend_nxt;
      iter_cnt   <= iter_nxt;
      sample_idx <= smp_nxt;
      en_q       <= en_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
    end
  end

  assign {select_initial, en_fwd2, en_fwd3, en_err,
          en_dlt3, en_dlt2, en_upd} = en_q;

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Directed bench for nn_train_sequencer: three instances
// (N_ITER 3, 6, 10) exercised by one linear sequence.
module tb_nn_train_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res, stop;
  logic [2:0] st;

  logic [6:0]  en   [3];
  logic        busy [3];
  logic        done [3];
  logic [15:0] it   [3];
  logic [1:0]  sm   [3];

  nn_train_sequencer #(.N_ITER(3), .N_SAMPLES(4), .ITER_W(16), .SMP_W(2)) u3 (
    .clk(clk), .res(res), .start(st[0]), .stop(stop),
    .select_initial(en[0][6]), .en_fwd2(en[0][5]), .en_fwd3(en[0][4]),
    .en_err(en[0][3]), .en_dlt3(en[0][2]), .en_dlt2(en[0][1]),
    .en_upd(en[0][0]), .sample_idx(sm[0]), .iter_cnt(it[0]),
    .busy(busy[0]), .done(done[0]));

  nn_train_sequencer #(.N_ITER(6), .N_SAMPLES(4), .ITER_W(16), .SMP_W(2)) u6 (
    .clk(clk), .res(res), .start(st[1]), .stop(stop),
    .select_initial(en[1][6]), .en_fwd2(en[1][5]), .en_fwd3(en[1][4]),
    .en_err(en[1][3]), .en_dlt3(en[1][2]), .en_dlt2(en[1][1]),
    .en_upd(en[1][0]), .sample_idx(sm[1]), .iter_cnt(it[1]),
    .busy(busy[1]), .done(done[1]));

  nn_train_sequencer #(.N_ITER(10), .N_SAMPLES(4), .ITER_W(16), .SMP_W(2)) u10 (
    .clk(clk), .res(res), .start(st[2]), .stop(stop),
    .select_initial(en[2][6]), .en_fwd2(en[2][5]), .en_fwd3(en[2][4]),
    .en_err(en[2][3]), .en_dlt3(en[2][2]), .en_dlt2(en[2][1]),
    .en_upd(en[2][0]), .sample_idx(sm[2]), .iter_cnt(it[2]),
    .busy(busy[2]), .done(done[2]));

  int n_cmp, n_bad, cyc;
  int busy_c [3];
  int done_c [3];
  int next_c [3];
  int bad_c  [3];
  int first_b[3];
  int done_at[3];
  int en_c   [3][7];
  logic prev_f2;
  int seq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      busy_c[k]  = 0;
      done_c[k]  = 0;
      next_c[k]  = 0;
      bad_c[k]   = 0;
      first_b[k] = -1;
      done_at[k] = -1;
      for (int b = 0; b < 7; b++) en_c[k][b] = 0;
    end
    seq.delete();
    prev_f2 = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) begin
        busy_c[k]++;
        if (first_b[k] < 0) first_b[k] = cyc;
        if ($countones(en[k]) == 0) next_c[k]++;
      end
      if ($countones(en[k]) > (busy[k] ? 1 : 0)) bad_c[k]++;
      if (done[k]) begin
        done_c[k]++;
        done_at[k] = cyc;
        if (busy[k]) bad_c[k]++;
      end
      for (int b = 0; b < 7; b++) en_c[k][b] += int'(en[k][b]);
    end
    if (en[1][5] && !prev_f2) seq.push_back(int'(sm[1]));
    prev_f2 = en[1][5];
  endtask

  task automatic chk_run(input int k, input string p, input int n,
                         input int exp_sm);
    int exp_en[7];
    exp_en = '{3*n, 2*n, 2*n, n, 2*n, 2*n, 1};
    chk({p, "_busy"}, busy_c[k], 1 + 13*n);
    chk({p, "_span"}, done_at[k] - first_b[k], 1 + 13*n);
    chk({p, "_done"}, done_c[k], 1);
    chk({p, "_next"}, next_c[k], n);
    chk({p, "_onehot"}, bad_c[k], 0);
    chk({p, "_iter"}, it[k], n);
    chk({p, "_smp"}, sm[k], exp_sm);
    for (int b = 0; b < 7; b++)
      chk($sformatf("%s_en%0d", p, b), en_c[k][b], exp_en[b]);
  endtask

  initial begin
    res = 1'b1; st = 3'b0; stop = 1'b0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    clr();
    tick(); tick();
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_out%0d", k),
          {busy[k], done[k], en[k], it[k], sm[k]}, 0);
    res = 1'b0;
    tick();

    clr();
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (55) tick();
    chk_run(0, "run3", 3, 3);

    clr();
    st[1] = 1'b1; tick(); st[1] = 1'b0;
    repeat (90) tick();
    chk_run(1, "wrap6", 6, 2);
    chk("wrap6_nseq", seq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("wrap6_seq%0d", i),
          (i < seq.size()) ? seq[i] : -1, i % 4);

    clr();
    st[2] = 1'b1; tick(); st[2] = 1'b0;
    repeat (19) tick();
    chk("stop_at_dlt3", en[2][2], 1);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (30) tick();
    chk_run(2, "stop10", 2, 2);
    chk("stop_idle_u3", busy_c[0], 0);
    chk("stop_idle_u6", busy_c[1], 0);

    clr();
    stop = 1'b1;
    repeat (3) tick();
    chk("idle_stop", busy_c[0], 0);
    st[0] = 1'b1; tick(); st[0] = 1'b0; stop = 1'b0;
    repeat (4) tick();
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (14) tick();
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (40) tick();
    chk_run(0, "ign3", 3, 3);

    clr();
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (23) tick();
    chk("pre_rst_upd", en[0][0], 1);
    chk("pre_rst_iter", it[0], 1);
    chk("pre_rst_smp", sm[0], 1);
    #2 res = 1'b1;
    #1;
    chk("mid_rst_out", {busy[0], done[0], en[0], it[0], sm[0]}, 0);
    tick(); tick();
    res = 1'b0;
    repeat (5) tick();
    chk("rst_no_done", done_c[0], 0);
    chk("rst_idle", busy[0], 0);

    clr();
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (55) tick();
    chk_run(0, "fresh3", 3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
